// File: rtl/main_memory_model_queued.sv
// main_memory_model_queued: in-order, queued whole-line memory responder.
// Requests are buffered in a small FIFO. The head entry waits a programmable
// latency, then it is accessed, popped, and answered with a one-cycle rsp_valid.
// Optional feature macro: MEM_MODEL_RANDOM_LATENCY_EN. When it is defined, each
// head latency is drawn from an 8-bit LFSR in the range 1..LATENCY.
module main_memory_model_queued #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 128,
  parameter int DEPTH_LOG2  = 12,
  parameter int LATENCY     = 15,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_rw,
  output logic [DATA_W-1:0] rsp_data
);
  localparam int OFFSET_W = $clog2(DATA_W/8);
  localparam int PTR_W    = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W    = $clog2(QUEUE_DEPTH+1);

  typedef struct packed {
    logic                  rw;
    logic [DEPTH_LOG2-1:0] idx;
    logic [DATA_W-1:0]     wdata;
  } req_t;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];
  req_t              fifo [QUEUE_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  state_t            state, state_nx;
  logic [3:0]        lat_cnt, lat_nx, lat_load;
  logic              push, access, full;
  req_t              head, incoming;
  logic              unused_addr;

  // Only the line-index bits of the address matter; the offset and upper bits are dropped.
  assign unused_addr = ^req_addr;

  assign incoming = '{rw: req_rw, idx: req_addr[OFFSET_W +: DEPTH_LOG2], wdata: req_wdata};
  assign head      = fifo[rd_ptr];
  assign full      = (count == CNT_W'(QUEUE_DEPTH));
  // A full queue refuses even on the cycle the head pops (no bypass).
  assign req_ready = rst_n & ~full;
  assign push      = req_valid & req_ready;

`ifdef MEM_MODEL_RANDOM_LATENCY_EN
  logic [7:0] lfsr;

  // Free-running LFSR (x^8+x^6+x^5+x^4+1) that picks per-head latencies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 8'hA5;
    else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign lat_load = 4'((lfsr % 8'(LATENCY)) + 8'd1);
`else
  assign lat_load = 4'(LATENCY);
`endif

  // Head FSM: load the latency counter when an entry becomes head. Access when it reaches 1.
  always_comb begin
    state_nx = state;
    lat_nx   = lat_cnt;
    access   = 1'b0;
    case (state)
      S_IDLE: begin
        if (push) begin
          state_nx = S_WAIT;
          lat_nx   = lat_load;
        end
      end
      S_WAIT: begin
        if (lat_cnt == 4'd1) begin
          access = 1'b1;
          // Another entry (queued, or pushed this very edge) becomes head immediately.
          if (count > CNT_W'(1) || push) lat_nx = lat_load;
          else                           state_nx = S_IDLE;
        end else begin
          lat_nx = lat_cnt - 4'd1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // FSM state and latency counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      lat_cnt <= 4'd0;
    end else begin
      state   <= state_nx;
      lat_cnt <= lat_nx;
    end
  end

  // FIFO pointers and occupancy. Push and pop on the same edge leave the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (access) rd_ptr <= rd_ptr + 1'b1;
      if (push && !access)      count <= count + 1'b1;
      else if (!push && access) count <= count - 1'b1;
    end
  end

  // FIFO payload storage; it needs no reset because the pointers gate it.
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= incoming;
  end

  // Line array write port; the array contents survive reset.
  always_ff @(posedge clk) begin
    if (access && head.rw) mem[head.idx] <= head.wdata;
  end

  // Response: pulse once per completed request. rsp_data holds the last read line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rw    <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= access;
      if (access) begin
        rsp_rw <= head.rw;
        if (!head.rw) rsp_data <= mem[head.idx];
      end
    end
  end

endmodule

// File: tb/tb_main_memory_model_queued.sv
// Self-checking bench for main_memory_model_queued (default build, LATENCY=15).
// A vector table plus hand-written sequences push expectations into a scoreboard.
// A negedge monitor pops each expectation and checks rw, data and completion cycle.
module tb_main_memory_model_queued;
  localparam int AW  = 32;
  localparam int DW  = 128;
  localparam int LAT = 15;

  localparam logic [DW-1:0] PAT_AB = {16{8'hAB}};
  localparam logic [DW-1:0] PAT_D  = {4{32'hDEAD_BEEF}};
  localparam logic [DW-1:0] PAT_55 = {16{8'h55}};
  localparam logic [DW-1:0] PAT_77 = {8{16'h7707}};
  localparam logic [DW-1:0] PAT_12 = 128'h1234;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          req_valid = 1'b0, req_rw = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready, rsp_valid, rsp_rw;
  logic [DW-1:0] rsp_data;

  main_memory_model_queued dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rw(rsp_rw), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic rw; logic [DW-1:0] data; int due; } exp_t;
  typedef struct { logic rw; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [DW-1:0] exp; } vec_t;

  exp_t          sb[$];
  int            last_due = 0;
  int            n_chk = 0, n_pass = 0;
  logic [DW-1:0] model [8];
  logic [DW-1:0] last_rd;

  function automatic void check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Scoreboard monitor: every response must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_rsp: rsp_valid=1 at cycle %0d, want no response", cyc);
      end else begin
        e = sb.pop_front();
        check("rsp_rw", DW'(rsp_rw), DW'(e.rw));
        check("rsp_data", rsp_data, e.data);
        check("rsp_cycle", DW'(cyc), DW'(e.due));
      end
    end
  end

  // Drive one request until accepted. Record its accept edge and expected response.
  task automatic send(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [DW-1:0] exp, output int acc);
    logic rdy;
    exp_t e;
    int   eh;
    acc = -1;
    @(negedge clk);
    req_valid = 1'b1; req_rw = rw; req_addr = a; req_wdata = d;
    for (int k = 0; k < 200; k++) begin
      rdy = req_ready;
      @(posedge clk); #1;
      if (rdy) begin acc = cyc; break; end
      @(negedge clk);
    end
    if (acc < 0) begin
      n_chk++;
      $display("FAIL accept_timeout: addr %h not accepted within 200 cycles", a);
    end else begin
      eh = (last_due > acc) ? last_due : acc;
      e.rw = rw; e.data = exp; e.due = eh + LAT;
      last_due = e.due;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 1500 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL drain_timeout: %0d responses missing", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    vec_t vt[11];
    int   acc[5];
    int   dummy, nrsp;
    logic rw;
    int   idx;
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    vt[0]  = '{1'b1, 32'h0000_0040, PAT_AB, '0};
    vt[1]  = '{1'b0, 32'h0000_0040, '0,     PAT_AB};
    vt[2]  = '{1'b1, 32'h0001_0000, PAT_12, PAT_AB};
    vt[3]  = '{1'b0, 32'h0000_0000, '0,     PAT_12};
    vt[4]  = '{1'b0, 32'h0000_000F, '0,     PAT_12};
    vt[5]  = '{1'b1, 32'h0000_0080, PAT_D,  PAT_12};
    vt[6]  = '{1'b0, 32'h0000_0080, '0,     PAT_D};
    vt[7]  = '{1'b1, 32'h0000_0090, PAT_55, PAT_D};
    vt[8]  = '{1'b0, 32'h0000_0090, '0,     PAT_55};
    vt[9]  = '{1'b1, 32'h0000_FFF0, PAT_77, PAT_55};
    vt[10] = '{1'b0, 32'h0001_FFF0, '0,     PAT_77};

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_req_ready", DW'(req_ready), '0);
    check("rst_rsp_valid", DW'(rsp_valid), '0);
    check("rst_rsp_rw", DW'(rsp_rw), '0);
    check("rst_rsp_data", rsp_data, '0);
    rst_n = 1'b1;
    #1 check("ready_after_rst", DW'(req_ready), DW'(1'b1));

    // Single write into an empty queue completes exactly LAT cycles after acceptance
    send(vt[0].rw, vt[0].addr, vt[0].wdata, vt[0].exp, dummy);
    idle();
    drain();

    // Remaining vectors back-to-back: in-order service, index wrap, offset ignored
    for (int i = 1; i < 11; i++) send(vt[i].rw, vt[i].addr, vt[i].wdata, vt[i].exp, dummy);
    idle();
    drain();

    // Five reads held valid: four fill the queue, the fifth waits for the first pop
    send(1'b0, 32'h40, '0, PAT_AB, acc[0]);
    send(1'b0, 32'h80, '0, PAT_D,  acc[1]);
    send(1'b0, 32'h90, '0, PAT_55, acc[2]);
    send(1'b0, 32'h0,  '0, PAT_12, acc[3]);
    check("full_ready_low", DW'(req_ready), '0);
    send(1'b0, 32'hFFF0, '0, PAT_77, acc[4]);
    idle();
    check("b2b_accept", DW'(acc[3] - acc[0]), DW'(3));
    check("fifth_accept", DW'(acc[4] - acc[0]), DW'(LAT + 1));
    drain();

    // Reset in the middle of WAIT drops queued reads with no response
    send(1'b0, 32'h40, '0, PAT_AB, dummy);
    send(1'b0, 32'h80, '0, PAT_D,  dummy);
    idle();
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb.delete();
    last_due = 0;
    check("midrst_req_ready", DW'(req_ready), '0);
    check("midrst_rsp_valid", DW'(rsp_valid), '0);
    check("midrst_rsp_data", rsp_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    nrsp = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rsp_valid) nrsp++;
    end
    check("no_rsp_after_rst", DW'(nrsp), '0);
    check("rsp_data_after_rst", rsp_data, '0);
    send(1'b0, 32'h40, '0, PAT_AB, dummy);
    idle();
    drain();

    // Random traffic over eight lines with random offsets and upper bits, checked against an array model
    last_rd = PAT_AB;
    for (int i = 0; i < 8; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      model[i] = d;
      a = (AW'($urandom_range(0, 255)) << 16) | (AW'(i) << 4) | AW'($urandom_range(0, 15));
      send(1'b1, a, d, last_rd, dummy);
    end
    for (int i = 0; i < 60; i++) begin
      rw  = 1'($urandom_range(0, 1));
      idx = $urandom_range(0, 7);
      a   = (AW'($urandom_range(0, 255)) << 16) | (AW'(idx) << 4) | AW'($urandom_range(0, 15));
      if (rw) begin
        d = {$urandom, $urandom, $urandom, $urandom};
        send(1'b1, a, d, last_rd, dummy);
        model[idx] = d;
      end else begin
        last_rd = model[idx];
        send(1'b0, a, '0, last_rd, dummy);
      end
      if ($urandom_range(0, 3) == 0) begin
        idle();
        repeat ($urandom_range(0, 20)) @(negedge clk);
      end
    end
    idle();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
